// File: rtl/bt_cmd_decoder.sv
// Bluetooth command decoder: turns strobed ASCII bytes into single-byte commands
// and "#RCV;" SET frames, with an inter-byte timeout while a frame is open.
module bt_cmd_decoder #(
  parameter int NUM_W            = 4,
  parameter int TIMEOUT_CYCLES   = 5000000,
  parameter int CASE_INSENSITIVE = 1
) (
  input  logic             CLK_100MHz,
  input  logic             rst_n,
  input  logic [7:0]       sig_bt,
  input  logic             bt_valid,
  output logic             cmd_valid,
  output logic [2:0]       cmd_type,
  output logic [NUM_W-1:0] sig_num,
  output logic [3:0]       cmd_row,
  output logic [3:0]       cmd_col,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ROW  = 3'd1;
  localparam logic [2:0] S_COL  = 3'd2;
  localparam logic [2:0] S_VAL  = 3'd3;
  localparam logic [2:0] S_TERM = 3'd4;

  localparam logic [2:0] T_NONE    = 3'd0;
  localparam logic [2:0] T_DIGIT   = 3'd1;
  localparam logic [2:0] T_MOVE    = 3'd2;
  localparam logic [2:0] T_SET     = 3'd3;
  localparam logic [2:0] T_RESTART = 3'd4;

  logic [2:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       row_r, col_r, val_r;
  logic             cmd_valid_r, frame_err_r, busy_r;
  logic [2:0]       cmd_type_r;
  logic [NUM_W-1:0] sig_num_r;
  logic [3:0]       cmd_row_r, cmd_col_r;

  logic [2:0] nxt_state_s;
  logic       emit_s, err_s, timeout_s;
  logic [2:0] etype_s;
  logic [3:0] enum_s, erow_s, ecol_s;
  logic       ld_row_s, ld_col_s, ld_val_s;
  logic [7:0] up_s;
  logic       is_digit_s, is_nz_s;

  // Byte classification; lowercase folding only matters for the move/restart letters
  always_comb begin
    if ((CASE_INSENSITIVE != 0) && (sig_bt >= 8'h61) && (sig_bt <= 8'h7A)) begin
      up_s = sig_bt - 8'h20;
    end else begin
      up_s = sig_bt;
    end
    is_digit_s = (sig_bt >= 8'h30) && (sig_bt <= 8'h39);
    is_nz_s    = is_digit_s && (sig_bt[3:0] != 4'd0);
  end

  // Next-state and command decode; a byte always takes priority over a pending timeout
  always_comb begin
    nxt_state_s = state_r;
    emit_s      = 1'b0;
    err_s       = 1'b0;
    etype_s     = T_NONE;
    enum_s      = 4'd0;
    erow_s      = 4'd0;
    ecol_s      = 4'd0;
    ld_row_s    = 1'b0;
    ld_col_s    = 1'b0;
    ld_val_s    = 1'b0;
    timeout_s   = (state_r != S_IDLE) && (cnt_r == TO_LAST);
    if (bt_valid) begin
      if (sig_bt == 8'h23) begin
        nxt_state_s = S_ROW;
        err_s       = (state_r != S_IDLE);
      end else begin
        case (state_r)
          S_IDLE: begin
            if (is_digit_s) begin
              emit_s  = 1'b1;
              etype_s = T_DIGIT;
              enum_s  = sig_bt[3:0];
            end else begin
              case (up_s)
                8'h57: begin emit_s = 1'b1; etype_s = T_MOVE; enum_s = 4'd0; end
                8'h41: begin emit_s = 1'b1; etype_s = T_MOVE; enum_s = 4'd1; end
                8'h53: begin emit_s = 1'b1; etype_s = T_MOVE; enum_s = 4'd2; end
                8'h44: begin emit_s = 1'b1; etype_s = T_MOVE; enum_s = 4'd3; end
                8'h52: begin emit_s = 1'b1; etype_s = T_RESTART; enum_s = 4'd0; end
                8'h0D, 8'h0A, 8'h20: err_s = 1'b0;
                default: err_s = 1'b1;
              endcase
            end
          end
          S_ROW: begin
            if (is_nz_s) begin
              ld_row_s    = 1'b1;
              nxt_state_s = S_COL;
            end else begin
              err_s       = 1'b1;
              nxt_state_s = S_IDLE;
            end
          end
          S_COL: begin
            if (is_nz_s) begin
              ld_col_s    = 1'b1;
              nxt_state_s = S_VAL;
            end else begin
              err_s       = 1'b1;
              nxt_state_s = S_IDLE;
            end
          end
          S_VAL: begin
            if (is_digit_s) begin
              ld_val_s    = 1'b1;
              nxt_state_s = S_TERM;
            end else begin
              err_s       = 1'b1;
              nxt_state_s = S_IDLE;
            end
          end
          S_TERM: begin
            if (sig_bt == 8'h3B) begin
              emit_s  = 1'b1;
              etype_s = T_SET;
              enum_s  = val_r;
              erow_s  = row_r;
              ecol_s  = col_r;
            end else begin
              err_s = 1'b1;
            end
            nxt_state_s = S_IDLE;
          end
          default: nxt_state_s = S_IDLE;
        endcase
      end
    end else if (timeout_s) begin
      err_s       = 1'b1;
      nxt_state_s = S_IDLE;
    end else begin
      nxt_state_s = state_r;
    end
  end

  // State, timeout counter and latched frame fields
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      row_r   <= 4'd0;
      col_r   <= 4'd0;
      val_r   <= 4'd0;
    end else begin
      state_r <= nxt_state_s;
      if (bt_valid || (state_r == S_IDLE)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      if (ld_row_s) row_r <= sig_bt[3:0];
      if (ld_col_s) col_r <= sig_bt[3:0];
      if (ld_val_s) val_r <= sig_bt[3:0];
    end
  end

  // Registered outputs; command fields hold until the next command
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      cmd_type_r  <= T_NONE;
      sig_num_r   <= '0;
      cmd_row_r   <= 4'd0;
      cmd_col_r   <= 4'd0;
    end else begin
      cmd_valid_r <= emit_s;
      frame_err_r <= err_s;
      busy_r      <= (nxt_state_s != S_IDLE);
      if (emit_s) begin
        cmd_type_r <= etype_s;
        sig_num_r  <= NUM_W'(enum_s);
        cmd_row_r  <= erow_s;
        cmd_col_r  <= ecol_s;
      end
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;
  assign cmd_type  = cmd_type_r;
  assign sig_num   = sig_num_r;
  assign cmd_row   = cmd_row_r;
  assign cmd_col   = cmd_col_r;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Scoreboard bench for bt_cmd_decoder: instance 0 is case-insensitive, instance 1
// case-sensitive, both with a short timeout.
module tb_bt_cmd_decoder;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0][7:0] sb;
  logic [1:0]      bv;
  logic [1:0]      cv, fe, by;
  logic [1:0][2:0] ct;
  logic [1:0][3:0] sn, cr, cc;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_cyc = 0;

  typedef struct {
    string      name;
    logic       err;
    logic [2:0] typ;
    logic [3:0] num, row, col;
    int         at;
  } exp_t;
  exp_t q[2][$];
  logic [1:0][2:0] h_typ;
  logic [1:0][3:0] h_num, h_row, h_col;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bt_cmd_decoder #(.NUM_W(4), .TIMEOUT_CYCLES(TO), .CASE_INSENSITIVE(1)) dut0 (
    .CLK_100MHz(clk), .rst_n(rst_n), .sig_bt(sb[0]), .bt_valid(bv[0]),
    .cmd_valid(cv[0]), .cmd_type(ct[0]), .sig_num(sn[0]), .cmd_row(cr[0]),
    .cmd_col(cc[0]), .frame_err(fe[0]), .busy(by[0]));

  bt_cmd_decoder #(.NUM_W(4), .TIMEOUT_CYCLES(TO), .CASE_INSENSITIVE(0)) dut1 (
    .CLK_100MHz(clk), .rst_n(rst_n), .sig_bt(sb[1]), .bt_valid(bv[1]),
    .cmd_valid(cv[1]), .cmd_type(ct[1]), .sig_num(sn[1]), .cmd_row(cr[1]),
    .cmd_col(cc[1]), .frame_err(fe[1]), .busy(by[1]));

  // Monitors: every output pulse must match the oldest expectation, in the right cycle
  for (genvar g = 0; g < 2; g++) begin : g_mon
    exp_t e;
    always @(negedge clk) begin
      if (rst_n && (cv[g] || fe[g])) begin
        checks++;
        if (cv[g] && fe[g]) begin
          errors++;
          $display("FAIL excl[%0d]: cmd_valid=1 frame_err=1 at cycle %0d, required not both", g, cyc);
        end
        if (q[g].size() == 0) begin
          errors++;
          $display("FAIL unexpected[%0d]: got cv=%0b fe=%0b typ=%0d num=%0d row=%0d col=%0d at cycle %0d, required no output",
                   g, cv[g], fe[g], ct[g], sn[g], cr[g], cc[g], cyc);
        end else begin
          e = q[g].pop_front();
          checks++;
          if ({cv[g], fe[g], ct[g], sn[g], cr[g], cc[g]} !== {~e.err, e.err, e.typ, e.num, e.row, e.col}
              || cyc != e.at) begin
            errors++;
            $display("FAIL %s[%0d]: got cv=%0b fe=%0b typ=%0d num=%0d row=%0d col=%0d cyc=%0d, required cv=%0b fe=%0b typ=%0d num=%0d row=%0d col=%0d cyc=%0d",
                     e.name, g, cv[g], fe[g], ct[g], sn[g], cr[g], cc[g], cyc,
                     ~e.err, e.err, e.typ, e.num, e.row, e.col, e.at);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] b);
    sb[i] = b;
    bv[i] = 1'b1;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    bv[i] = 1'b0;
  endtask

  task automatic send_str(input int i, input string s);
    for (int k = 0; k < s.len(); k++) send(i, s[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_cmd(input int i, input string nm, input logic [2:0] t,
                         input logic [3:0] n, input logic [3:0] r, input logic [3:0] c);
    exp_t e;
    h_typ[i] = t; h_num[i] = n; h_row[i] = r; h_col[i] = c;
    e.name = nm; e.err = 1'b0; e.typ = t; e.num = n; e.row = r; e.col = c;
    e.at = last_cyc + 1;
    q[i].push_back(e);
  endtask

  task automatic exp_err(input int i, input string nm, input int at);
    exp_t e;
    e.name = nm; e.err = 1'b1; e.typ = h_typ[i]; e.num = h_num[i];
    e.row = h_row[i]; e.col = h_col[i]; e.at = at;
    q[i].push_back(e);
  endtask

  initial begin
    sb = '0; bv = '0;
    h_typ = '0; h_num = '0; h_row = '0; h_col = '0;
    #12;
    chk("reset_held", {18'd0, cv[0], ct[0], sn[0], cr[0], cc[0], fe[0], by[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("reset_state", {18'd0, cv[0], ct[0], sn[0], cr[0], cc[0], fe[0], by[0]}, 32'd0);

    // Single-byte commands, including a lowercase move and bad idle bytes
    send(0, 8'h37); exp_cmd(0, "digit7", 3'd1, 4'd7, 4'd0, 4'd0);
    idle(2);
    send(0, 8'h64); exp_cmd(0, "move_d", 3'd2, 4'd3, 4'd0, 4'd0);
    send(0, 8'h57); exp_cmd(0, "move_W", 3'd2, 4'd0, 4'd0, 4'd0);
    send(0, 8'h72); exp_cmd(0, "restart_r", 3'd4, 4'd0, 4'd0, 4'd0);
    send(0, 8'h78); exp_err(0, "idle_x", last_cyc + 1);
    send(0, 8'h3F); exp_err(0, "idle_q", last_cyc + 1);
    idle(3);

    // Spaced SET frame
    chk("busy_pre", {31'd0, by[0]}, 32'd0);
    send(0, 8'h23); chk("busy_after_hash", {31'd0, by[0]}, 32'd1);
    idle(9); send(0, 8'h33);
    idle(9); send(0, 8'h35);
    idle(9); send(0, 8'h39);
    idle(9); chk("busy_before_term", {31'd0, by[0]}, 32'd1);
    send(0, 8'h3B); exp_cmd(0, "set_359", 3'd3, 4'd9, 4'd3, 4'd5);
    chk("busy_after_term", {31'd0, by[0]}, 32'd0);

    // Timeout after "#1", then a fresh digit
    send_str(0, "#1"); exp_err(0, "timeout", last_cyc + TO + 1);
    idle(30);
    chk("busy_timeout", {31'd0, by[0]}, 32'd0);
    send(0, 8'h34); exp_cmd(0, "digit4", 3'd1, 4'd4, 4'd0, 4'd0);

    // Byte lands on the exact timeout cycle and wins
    send_str(0, "#1");
    idle(TO - 1);
    chk("busy_race", {31'd0, by[0]}, 32'd1);
    send_str(0, "23;"); exp_cmd(0, "set_race", 3'd3, 4'd3, 4'd1, 4'd2);

    // Malformed frames
    send_str(0, "#0"); exp_err(0, "row_zero", last_cyc + 1);
    chk("busy_row_zero", {31'd0, by[0]}, 32'd0);
    send_str(0, "#12#"); exp_err(0, "restart_hash", last_cyc + 1);
    chk("busy_restart", {31'd0, by[0]}, 32'd1);
    send_str(0, "345;"); exp_cmd(0, "set_345", 3'd3, 4'd5, 4'd3, 4'd4);
    send_str(0, "#123X"); exp_err(0, "term_X", last_cyc + 1);
    chk("busy_term_X", {31'd0, by[0]}, 32'd0);
    idle(3);

    // Asynchronous reset mid-frame, then whitespace and a full frame
    send_str(0, "#12");
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {18'd0, cv[0], ct[0], sn[0], cr[0], cc[0], fe[0], by[0]}, 32'd0);
    h_typ = '0; h_num = '0; h_row = '0; h_col = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    send(0, 8'h0D); send(0, 8'h20);
    idle(3);
    chk("busy_ws", {31'd0, by[0]}, 32'd0);
    send_str(0, "#999;"); exp_cmd(0, "set_999", 3'd3, 4'd9, 4'd9, 4'd9);

    // Case-sensitive instance: lowercase rejected, fields held
    send(1, 8'h35); exp_cmd(1, "cs_digit5", 3'd1, 4'd5, 4'd0, 4'd0);
    send(1, 8'h64); exp_err(1, "cs_lower_d", last_cyc + 1);
    send(1, 8'h44); exp_cmd(1, "cs_move_D", 3'd2, 4'd3, 4'd0, 4'd0);

    idle(TO + 5);
    chk("drain0", q[0].size(), 32'd0);
    chk("drain1", q[1].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
